// File: rtl/cc_posjug2_shifter_if.sv
// cc_posjug2_shifter_if: player-2 button, collision and position bus between game logic and shifter
interface cc_posjug2_shifter_if #(parameter int DATAWIDTH = 8);
  logic                 CC_POSJUG2_SHIFTER_left_In;
  logic                 CC_POSJUG2_SHIFTER_right_In;
  logic                 CC_POSJUG2_SHIFTER_collision_In;
  logic [DATAWIDTH-1:0] CC_POSJUG2_SHIFTER_posjug2_OutBUS;
  logic                 CC_POSJUG2_SHIFTER_frozen_Out;
  logic [3:0]           CC_POSJUG2_SHIFTER_hits_OutBUS;
  modport master (
    output CC_POSJUG2_SHIFTER_left_In, CC_POSJUG2_SHIFTER_right_In, CC_POSJUG2_SHIFTER_collision_In,
    input  CC_POSJUG2_SHIFTER_posjug2_OutBUS, CC_POSJUG2_SHIFTER_frozen_Out, CC_POSJUG2_SHIFTER_hits_OutBUS
  );
  modport slave (
    input  CC_POSJUG2_SHIFTER_left_In, CC_POSJUG2_SHIFTER_right_In, CC_POSJUG2_SHIFTER_collision_In,
    output CC_POSJUG2_SHIFTER_posjug2_OutBUS, CC_POSJUG2_SHIFTER_frozen_Out, CC_POSJUG2_SHIFTER_hits_OutBUS
  );
endinterface

// File: rtl/cc_posjug2_shifter.sv
// cc_posjug2_shifter: player-2 one-hot lane position with move cooldown and collision freeze; POSJUG2_WRAP_EN makes moves wrap at the edges
module cc_posjug2_shifter #(
  parameter int DATAWIDTH = 8,
  parameter int START_POS = 3,
  parameter int COOLDOWN  = 4,
  parameter int FREEZE    = 8
) (
  input logic CC_POSJUG2_SHIFTER_CLOCK_50,
  input logic CC_POSJUG2_SHIFTER_RESET_InHigh,
  cc_posjug2_shifter_if.slave bus
);
  typedef enum logic [1:0] {IDLE, COOL, FROZEN} state_t;
  localparam logic [DATAWIDTH-1:0] START = {{(DATAWIDTH-1){1'b0}}, 1'b1} << START_POS;
  localparam logic [7:0] COOL_LD = 8'(COOLDOWN - 1);
  localparam logic [7:0] FRZ_LD  = 8'(FREEZE - 1);
  state_t               r_state, w_state_n;
  logic [DATAWIDTH-1:0] r_pos, w_pos_n, w_pos_l, w_pos_r;
  logic [7:0]           r_cnt, w_cnt_n;
  logic [3:0]           r_hits, w_hits_n;
  logic                 r_left_q, r_right_q, r_frozen;
  logic                 w_left_edge, w_right_edge;
  assign w_left_edge  = bus.CC_POSJUG2_SHIFTER_left_In & ~r_left_q;
  assign w_right_edge = bus.CC_POSJUG2_SHIFTER_right_In & ~r_right_q;
`ifdef POSJUG2_WRAP_EN
  assign w_pos_l = {r_pos[DATAWIDTH-2:0], r_pos[DATAWIDTH-1]};
  assign w_pos_r = {r_pos[0], r_pos[DATAWIDTH-1:1]};
`else
  assign w_pos_l = r_pos[DATAWIDTH-1] ? r_pos : r_pos << 1;
  assign w_pos_r = r_pos[0] ? r_pos : r_pos >> 1;
`endif
  assign bus.CC_POSJUG2_SHIFTER_posjug2_OutBUS = r_pos;
  assign bus.CC_POSJUG2_SHIFTER_frozen_Out     = r_frozen;
  assign bus.CC_POSJUG2_SHIFTER_hits_OutBUS    = r_hits;
  // next state: collision outranks moves outside FROZEN; COOL and FROZEN count down to IDLE
  always_comb begin
    w_state_n = r_state;
    w_pos_n   = r_pos;
    w_cnt_n   = r_cnt;
    w_hits_n  = r_hits;
    if (r_state != FROZEN && bus.CC_POSJUG2_SHIFTER_collision_In) begin
      w_state_n = FROZEN;
      w_pos_n   = START;
      w_cnt_n   = FRZ_LD;
      w_hits_n  = r_hits + {3'b0, r_hits != 4'hf};
    end else if (r_state == IDLE) begin
      if (w_left_edge ^ w_right_edge) begin
        w_state_n = COOL;
        w_pos_n   = w_left_edge ? w_pos_l : w_pos_r;
        w_cnt_n   = COOL_LD;
      end
    end else begin
      w_pos_n   = r_state == FROZEN ? START : r_pos;
      w_state_n = r_cnt == 8'd0 ? IDLE : r_state;
      w_cnt_n   = r_cnt == 8'd0 ? r_cnt : r_cnt - 8'd1;
    end
  end
  // state, position, counters and button history registers
  always_ff @(posedge CC_POSJUG2_SHIFTER_CLOCK_50 or posedge CC_POSJUG2_SHIFTER_RESET_InHigh) begin
    if (CC_POSJUG2_SHIFTER_RESET_InHigh) begin
      r_state   <= IDLE;
      r_pos     <= START;
      r_cnt     <= 8'd0;
      r_hits    <= 4'd0;
      r_frozen  <= 1'b0;
      r_left_q  <= 1'b0;
      r_right_q <= 1'b0;
    end else begin
      r_state   <= w_state_n;
      r_pos     <= w_pos_n;
      r_cnt     <= w_cnt_n;
      r_hits    <= w_hits_n;
      r_frozen  <= w_state_n == FROZEN;
      r_left_q  <= bus.CC_POSJUG2_SHIFTER_left_In;
      r_right_q <= bus.CC_POSJUG2_SHIFTER_right_In;
    end
  end
endmodule

// File: tb/tb_cc_posjug2_shifter.sv
// tb_cc_posjug2_shifter: scoreboard bench for cc_posjug2_shifter against a cycle-index reference model
module tb_cc_posjug2_shifter;
  localparam int DW = 8, START_POS = 3, COOLDOWN = 4, FREEZE = 8;
  typedef struct {logic [7:0] pos; logic frozen; logic [3:0] hits;} exp_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  exp_t q[$];
  int   n_chk = 0, n_fail = 0;
  int   e = 0, m_idx, m_hits, m_fz_end, m_mv_k;
  logic m_pl, m_pr;
  cc_posjug2_shifter_if #(.DATAWIDTH(DW)) bus();
  cc_posjug2_shifter #(.DATAWIDTH(DW), .START_POS(START_POS), .COOLDOWN(COOLDOWN), .FREEZE(FREEZE)) dut (
    .CC_POSJUG2_SHIFTER_CLOCK_50(clk),
    .CC_POSJUG2_SHIFTER_RESET_InHigh(rst),
    .bus(bus.slave)
  );
  always #5 clk = ~clk;
  function automatic exp_t reset_exp();
    exp_t x;
    x.pos = 8'h1 << START_POS;
    x.frozen = 1'b0;
    x.hits = 4'd0;
    return x;
  endfunction
  task automatic model_reset();
    m_idx = START_POS;
    m_hits = 0;
    m_fz_end = -1000;
    m_mv_k = -1000;
    m_pl = 1'b0;
    m_pr = 1'b0;
  endtask
  // one clock edge of the reference: inputs only count once the freeze and cooldown windows have elapsed
  task automatic model_edge(input logic rr, l, r, c);
    logic le, re;
    exp_t x;
    if (rr) model_reset();
    else begin
      le = l & ~m_pl;
      re = r & ~m_pr;
      m_pl = l;
      m_pr = r;
      if (e > m_fz_end) begin
        if (c) begin
          m_idx = START_POS;
          m_fz_end = e + FREEZE;
          m_hits = m_hits < 15 ? m_hits + 1 : 15;
        end else if (e > m_mv_k + COOLDOWN && (le ^ re)) begin
          m_mv_k = e;
`ifdef POSJUG2_WRAP_EN
          m_idx = le ? (m_idx + 1) % DW : (m_idx + DW - 1) % DW;
`else
          m_idx = le ? (m_idx == DW - 1 ? m_idx : m_idx + 1) : (m_idx == 0 ? 0 : m_idx - 1);
`endif
        end
      end
    end
    x.pos = 8'h1 << m_idx;
    x.frozen = e < m_fz_end;
    x.hits = 4'(m_hits);
    q.push_back(x);
  endtask
  task automatic step(input logic rr, l, r, c);
    @(negedge clk);
    if (rr && !rst) q.push_back(reset_exp());
    rst = rr;
    bus.CC_POSJUG2_SHIFTER_left_In = l;
    bus.CC_POSJUG2_SHIFTER_right_In = r;
    bus.CC_POSJUG2_SHIFTER_collision_In = c;
    e++;
    model_edge(rr, l, r, c);
  endtask
  task automatic idle(input int n);
    repeat (n) step(1'b0, 1'b0, 1'b0, 1'b0);
  endtask
  // monitor: every clock edge or reset assertion presents a new output to score
  initial begin
    exp_t x;
    forever begin
      @(posedge clk or posedge rst);
      #1;
      if (q.size() != 0) begin
        x = q.pop_front();
        n_chk++;
        if (bus.CC_POSJUG2_SHIFTER_posjug2_OutBUS !== x.pos || bus.CC_POSJUG2_SHIFTER_frozen_Out !== x.frozen ||
            bus.CC_POSJUG2_SHIFTER_hits_OutBUS !== x.hits || !$onehot(bus.CC_POSJUG2_SHIFTER_posjug2_OutBUS)) begin
          n_fail++;
          $display("FAIL outputs t=%0t: pos=%h frozen=%b hits=%0d, expected pos=%h frozen=%b hits=%0d", $time,
                   bus.CC_POSJUG2_SHIFTER_posjug2_OutBUS, bus.CC_POSJUG2_SHIFTER_frozen_Out,
                   bus.CC_POSJUG2_SHIFTER_hits_OutBUS, x.pos, x.frozen, x.hits);
        end
      end
    end
  end
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, required completion before 200000");
    $fatal(1, "watchdog");
  end
  initial begin
    bus.CC_POSJUG2_SHIFTER_left_In = 1'b0;
    bus.CC_POSJUG2_SHIFTER_right_In = 1'b0;
    bus.CC_POSJUG2_SHIFTER_collision_In = 1'b0;
    model_reset();
    step(1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    idle(1);
    step(1'b0, 1'b0, 1'b1, 1'b0);
    idle(2);
    step(1'b0, 1'b0, 1'b1, 1'b0);
    idle(5);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    idle(1);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    idle(1);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    idle(5);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    idle(1);
    repeat (20) step(1'b0, 1'b1, 1'b0, 1'b0);
    idle(5);
    step(1'b0, 1'b1, 1'b1, 1'b0);
    idle(5);
    repeat (5) begin
      step(1'b0, 1'b1, 1'b0, 1'b0);
      idle(4);
    end
    step(1'b0, 1'b1, 1'b0, 1'b0);
    idle(5);
    repeat (10) begin
      step(1'b0, 1'b0, 1'b1, 1'b0);
      idle(4);
    end
    step(1'b1, 1'b0, 1'b0, 1'b0);
    idle(1);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    idle(4);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b1);
    idle(6);
    repeat (16) begin
      step(1'b0, 1'b0, 1'b0, 1'b1);
      idle(FREEZE);
    end
    repeat (400) step($urandom_range(0, 99) == 0, $urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0,
                      $urandom_range(0, 24) == 0);
    idle(3);
    @(negedge clk);
    n_chk++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d expectations left unscored, expected 0", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/cc_posjug2_shifter.md
# cc_posjug2_shifter

Player-2 position register for the road-crossing game. Converts player-2 left/right button presses into a one-hot lane position on an 8-bit bus. That bus feeds the player-2 position comparator directly, which matches it against row 0. The comparator's match output comes back into this block as the collision input, which freezes the player and returns it to the start lane.

## Interface
Parameters:
- DATAWIDTH, 8, width of the position bus; matches the comparator data width.
- START_POS, 3, bit index set after reset and after every collision; must be in 0..DATAWIDTH-1.
- COOLDOWN, 4, cycles after a move during which further presses are ignored; 1..255.
- FREEZE, 8, cycles the player is held after a collision; 1..255.

Ports:
- CC_POSJUG2_SHIFTER_CLOCK_50, in, 1, single system clock; all state changes on its rising edge.
- CC_POSJUG2_SHIFTER_RESET_InHigh, in, 1, asynchronous, active-high reset.
- CC_POSJUG2_SHIFTER_left_In, in, 1, left button level, already synchronized; high = pressed.
- CC_POSJUG2_SHIFTER_right_In, in, 1, right button level, already synchronized; high = pressed.
- CC_POSJUG2_SHIFTER_collision_In, in, 1, match flag from the player-2 position comparator.
- CC_POSJUG2_SHIFTER_posjug2_OutBUS, out, DATAWIDTH, one-hot position sent to the comparator.
- CC_POSJUG2_SHIFTER_frozen_Out, out, 1, high while in FROZEN.
- CC_POSJUG2_SHIFTER_hits_OutBUS, out, 4, saturating collision count.

## Operation
- Reset values:
  - posjug2 = 1<<START_POS
  - state = IDLE
  - frozen = 0
  - hits = 0
  - cooldown/freeze counter = 0
  - button history registers = 0
- Edge detection:
  - leftEdge = left_In & ~left_q; rightEdge = right_In & ~right_q.
  - left_q and right_q update every cycle in every state, so a held button never retriggers.
- FSM states: IDLE, COOL, FROZEN.
- In IDLE:
  - collision_In=1 → posjug2 = 1<<START_POS, counter = FREEZE-1, hits += 1 (saturates at 15), go to FROZEN.
  - Otherwise, exactly one edge → move, counter = COOLDOWN-1, go to COOL.
  - leftEdge shifts toward MSB (pos<<1); rightEdge shifts toward LSB (pos>>1).
  - Both edges in the same cycle → no move, stay in IDLE.
- In COOL:
  - Edges are discarded.
  - collision_In=1 takes priority and acts exactly as in IDLE.
  - Otherwise, counter==0 → IDLE; else counter decrements.
- In FROZEN:
  - Edges and collision_In are ignored; hits does not increment.
  - Position is held at START_POS.
  - counter==0 → IDLE; else counter decrements.
- Edge behaviour (without the Configuration macro):
  - Moving left at bit DATAWIDTH-1 or right at bit 0 leaves the position unchanged.
  - The attempt still enters COOL.
- posjug2 is always exactly one-hot; never zero and never multi-hot.
- Reset mid-operation returns to the reset values immediately, regardless of state or counter.

## Timing
- Move latency: a button high in the cycle sampled at edge k, with its history bit low, gives the updated posjug2 after edge k (1 cycle).
- Collision latency:
  - collision_In sampled high at edge k gives posjug2=START, frozen=1 and hits+1, all after edge k.
  - The comparator is combinational on posjug2, so a collision loop closes within one cycle.
- Cooldown timing:
  - COOL lasts exactly COOLDOWN cycles.
  - The first edge accepted after a move is the one sampled COOLDOWN+1 edges after the move edge.
- Freeze timing: frozen stays high for exactly FREEZE cycles.
- All outputs are registered; no combinational input-to-output paths.

## Configuration
- POSJUG2_WRAP_EN defined:
  - Moving left from bit DATAWIDTH-1 goes to bit 0.
  - Moving right from bit 0 goes to bit DATAWIDTH-1.
- POSJUG2_WRAP_EN undefined: moves saturate at the edges as in Operation.
- All other behaviour is identical in both builds.

## Test plan
- Reset check: assert reset mid-COOL → posjug2=8'h08, frozen=0, hits=0 asynchronously; after release, one left pulse → 8'h10 after 1 edge.
- Cooldown check (COOLDOWN=4): left pulse at edge 0, right pulses at edges 2 and 5.
  - After edge 0 → 8'h10.
  - Edge-2 pulse ignored.
  - Edge-5 pulse accepted → 8'h08.
- Held button: hold left for 20 cycles → exactly one move, 8'h08→8'h10.
- Simultaneous edges: left and right rise together in IDLE → posjug2 unchanged, state stays IDLE.
- Edge saturation/wrap: start at 8'h80, then a left pulse.
  - Without POSJUG2_WRAP_EN → 8'h80.
  - With it → 8'h01.
- Collision: pulse collision_In in COOL at 8'h20.
  - Next cycle: posjug2=8'h08, frozen=1, hits=1.
  - frozen stays high 8 cycles.
  - A second collision and left presses during FROZEN leave hits=1 and posjug2=8'h08.
  - Sixteen collisions total → hits=15.
